// File: rtl/seg7_pkg.sv
// -----------------------------------------------------------------------------
// seg7_pkg
// Shared definitions for the 7-segment scan decoder:
//   - segment bit positions within the active-low segment bus
//   - the 16-entry canonical active-low hex pattern table and the blank pattern
//   - decoder FSM state encoding and digit-select classification
// -----------------------------------------------------------------------------
package seg7_pkg;

  // Bit positions of each segment on the 7-bit bus.
  localparam int SEG_A = 6;
  localparam int SEG_B = 5;
  localparam int SEG_C = 4;
  localparam int SEG_D = 3;
  localparam int SEG_E = 2;
  localparam int SEG_F = 1;
  localparam int SEG_G = 0;

  localparam int SEG_W = 7;

  // All segments off (active-low).
  localparam logic [SEG_W-1:0] SEG_BLANK = 7'h7F;

  // Canonical active-low patterns for hex digits 0..F. Only these exact
  // forms decode; alternate 6/7/9 renderings are treated as invalid.
  localparam logic [SEG_W-1:0] SEG_TABLE [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  typedef enum logic [1:0] {
    IDLE     = 2'd0,  // no single digit selected
    SETTLING = 2'd1,  // single digit selected, waiting for stability
    HELD     = 2'd2   // captured, waiting for the bus to change
  } state_e;

  // Classification of an active-low digit-select vector.
  typedef enum logic [1:0] {
    SEL_NONE  = 2'd0,
    SEL_ONE   = 2'd1,
    SEL_MULTI = 2'd2
  } sel_e;

  function automatic sel_e classify_sel(input int zeros);
    if (zeros == 0)      return SEL_NONE;
    else if (zeros == 1) return SEL_ONE;
    else                 return SEL_MULTI;
  endfunction

endpackage

// File: rtl/seg7_pattern_decode.sv
// -----------------------------------------------------------------------------
// seg7_pattern_decode
// Combinational inverse of the hex-to-7-segment encoder table.
// Ports:
//   pattern_i   [6:0]  active-low segment pattern, [6]=a .. [0]=g
//   nibble_o    [3:0]  decoded hex value (0 when not a hex pattern)
//   is_hex_o           pattern exactly matches one canonical table entry
//   is_blank_o         pattern is all segments off
// -----------------------------------------------------------------------------
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern_i,
  output logic [3:0]       nibble_o,
  output logic             is_hex_o,
  output logic             is_blank_o
);

  // NOTE: every output gets a default before the loop so that no path leaves
  // it unassigned; otherwise synthesis infers a latch.
  always_comb begin
    nibble_o = '0;
    is_hex_o = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern_i == SEG_TABLE[i]) begin
        nibble_o = 4'(i);
        is_hex_o = 1'b1;
      end
    end
  end

  assign is_blank_o = (pattern_i == SEG_BLANK);

endmodule

// File: rtl/seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// seg7_scan_decoder
// Monitors a multiplexed active-low 7-segment bus, qualifies each digit's
// pattern once it has been stable for SETTLE_CYCLES, decodes it back to a hex
// nibble and assembles a DIGITS-wide value.
// Parameters:
//   DIGITS         number of multiplexed digits (1..8)
//   SETTLE_CYCLES  consecutive identical samples required before capture
// Ports:
//   i_clk, i_reset  clock, synchronous active-high reset
//   iv_seg_n [6:0]  segment lines, active-low, [6]=a .. [0]=g
//   iv_dig_n        digit selects, active-low, one-hot when driven
//   ov_value        decoded nibbles, digit k at [4k+3:4k]
//   ov_valid        digit k last captured as a valid hex pattern
//   ov_blank        digit k last captured as blank
//   o_frame_done    pulse when every digit has been captured since last pulse
//   o_error         pulse on an invalid captured pattern or a new multi-hot select
// -----------------------------------------------------------------------------
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int SETTLE_CYCLES = 4
) (
  input  logic                  i_clk,
  input  logic                  i_reset,
  input  logic [SEG_W-1:0]      iv_seg_n,
  input  logic [DIGITS-1:0]     iv_dig_n,
  output logic [4*DIGITS-1:0]   ov_value,
  output logic [DIGITS-1:0]     ov_valid,
  output logic [DIGITS-1:0]     ov_blank,
  output logic                  o_frame_done,
  output logic                  o_error
);

  localparam int SMP_W = SEG_W + DIGITS;
  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(SETTLE_CYCLES - 1);

  // Registered state
  logic [SMP_W-1:0]    sample_q;
  logic [CNT_W-1:0]    cnt_q;
  state_e              state_q;
  logic [DIGITS-1:0]   seen_q;
  logic [4*DIGITS-1:0] value_q;
  logic [DIGITS-1:0]   valid_q;
  logic [DIGITS-1:0]   blank_q;
  logic                frame_done_q;
  logic                error_q;

  // Next-state of the capture-related registers
  logic [DIGITS-1:0]   seen_d;
  logic [4*DIGITS-1:0] value_d;
  logic [DIGITS-1:0]   valid_d;
  logic [DIGITS-1:0]   blank_d;
  logic                frame_done_d;
  logic                error_d;

  logic [SMP_W-1:0]    incoming;
  logic                changed;
  logic                capture;
  int                  in_zeros;
  sel_e                in_sel;
  logic [IDX_W-1:0]    smp_idx;

  logic [3:0]          dec_nibble;
  logic                dec_is_hex;
  logic                dec_is_blank;

  assign incoming = {iv_seg_n, iv_dig_n};
  assign changed  = (incoming != sample_q);

  // Select classification: the incoming vector decides the next state when
  // the bus changes; the registered sample supplies the digit being captured.
  always_comb begin
    in_zeros = 0;
    smp_idx  = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!iv_dig_n[i]) in_zeros = in_zeros + 1;
      if (!sample_q[i]) smp_idx  = IDX_W'(i);
    end
  end

  assign in_sel = classify_sel(in_zeros);

  seg7_pattern_decode u_decode (
    .pattern_i  (sample_q[DIGITS +: SEG_W]),
    .nibble_o   (dec_nibble),
    .is_hex_o   (dec_is_hex),
    .is_blank_o (dec_is_blank)
  );

  // A capture needs the bus to still match the sample on the capture edge;
  // a change on that edge aborts it.
  assign capture = !changed && (state_q == SETTLING) && (cnt_q == CNT_MAX);

  always_comb begin
    value_d      = value_q;
    valid_d      = valid_q;
    blank_d      = blank_q;
    seen_d       = seen_q;
    frame_done_d = 1'b0;
    error_d      = changed && (in_sel == SEL_MULTI);
    if (capture) begin
      if (dec_is_hex) begin
        value_d[{smp_idx, 2'b00} +: 4] = dec_nibble;
        valid_d[smp_idx]               = 1'b1;
        blank_d[smp_idx]               = 1'b0;
      end else if (dec_is_blank) begin
        valid_d[smp_idx] = 1'b0;
        blank_d[smp_idx] = 1'b1;
      end else begin
        valid_d[smp_idx] = 1'b0;
        blank_d[smp_idx] = 1'b0;
        error_d          = 1'b1;
      end
      seen_d[smp_idx] = 1'b1;
      if (&seen_d) begin
        frame_done_d = 1'b1;
        seen_d       = '0;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // updates from the same pre-edge values regardless of statement order.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      sample_q     <= {SEG_BLANK, {DIGITS{1'b1}}};
      cnt_q        <= '0;
      state_q      <= IDLE;
      seen_q       <= '0;
      value_q      <= '0;
      valid_q      <= '0;
      blank_q      <= '0;
      frame_done_q <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      sample_q     <= incoming;
      value_q      <= value_d;
      valid_q      <= valid_d;
      blank_q      <= blank_d;
      seen_q       <= seen_d;
      frame_done_q <= frame_done_d;
      error_q      <= error_d;

      if (changed) begin
        cnt_q <= '0;
        case (in_sel)
          SEL_ONE: state_q <= SETTLING;
          default: state_q <= IDLE;
        endcase
      end else begin
        if (cnt_q != CNT_MAX) cnt_q <= cnt_q + 1'b1;
        if (capture) state_q <= HELD;
      end
    end
  end

  assign ov_value     = value_q;
  assign ov_valid     = valid_q;
  assign ov_blank     = blank_q;
  assign o_frame_done = frame_done_q;
  assign o_error      = error_q;

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_decoder
// Directed scenarios followed by randomized bus activity. A reference model
// tracks how long the bus has been stable and applies the capture rules
// directly; every cycle the DUT outputs are compared against it.
// -----------------------------------------------------------------------------
module tb_seg7_scan_decoder;

  localparam int DIGITS = 4;
  localparam int SETTLE = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [6:0]  seg;
  logic [3:0]  dig;
  logic [15:0] ov_value;
  logic [3:0]  ov_valid;
  logic [3:0]  ov_blank;
  logic        o_frame_done;
  logic        o_error;

  always #5 clk = ~clk;

  seg7_scan_decoder #(
    .DIGITS        (DIGITS),
    .SETTLE_CYCLES (SETTLE)
  ) dut (
    .i_clk        (clk),
    .i_reset      (rst),
    .iv_seg_n     (seg),
    .iv_dig_n     (dig),
    .ov_value     (ov_value),
    .ov_valid     (ov_valid),
    .ov_blank     (ov_blank),
    .o_frame_done (o_frame_done),
    .o_error      (o_error)
  );

  // Canonical active-low hex patterns 0..F.
  logic [6:0] hex_tab [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h0C, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  int total  = 0;
  int bad    = 0;
  int cyc    = 0;
  int fd_cnt = 0;
  int er_cnt = 0;

  // Reference model state
  logic [15:0] m_value = '0;
  logic [3:0]  m_valid = '0;
  logic [3:0]  m_blank = '0;
  logic [3:0]  m_seen  = '0;
  logic        m_fd    = 1'b0;
  logic        m_err   = 1'b0;
  logic [10:0] m_prev  = {7'h7F, 4'hF};
  int          m_run   = 0;

  // 0..15 for a hex pattern, 16 for blank, -1 for anything else.
  function automatic int decode(input logic [6:0] p);
    int r;
    r = -1;
    if (p == 7'h7F) r = 16;
    for (int i = 0; i < 16; i++)
      if (hex_tab[i] == p) r = i;
    return r;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
    end
  endtask

  // Applies one clock edge worth of behaviour to the reference model.
  // m_run counts how many consecutive edges have sampled the current bus
  // value; a digit is captured on the edge where that reaches SETTLE+1.
  task automatic model_edge();
    logic [10:0] cur;
    int zeros;
    int k;
    int d;
    m_fd  = 1'b0;
    m_err = 1'b0;
    if (rst) begin
      m_value = '0;
      m_valid = '0;
      m_blank = '0;
      m_seen  = '0;
      m_prev  = {7'h7F, 4'hF};
      m_run   = 0;
    end else begin
      cur   = {seg, dig};
      zeros = $countones(~dig);
      if (cur != m_prev) begin
        m_run = 1;
        if (zeros > 1) m_err = 1'b1;
      end else begin
        m_run++;
      end
      if (m_run == SETTLE + 1 && zeros == 1) begin
        k = 0;
        for (int i = 0; i < DIGITS; i++)
          if (!dig[i]) k = i;
        d = decode(seg);
        if (d >= 0 && d < 16) begin
          m_value[4*k +: 4] = 4'(d);
          m_valid[k] = 1'b1;
          m_blank[k] = 1'b0;
        end else if (d == 16) begin
          m_valid[k] = 1'b0;
          m_blank[k] = 1'b1;
        end else begin
          m_valid[k] = 1'b0;
          m_blank[k] = 1'b0;
          m_err      = 1'b1;
        end
        m_seen[k] = 1'b1;
        if (&m_seen) begin
          m_fd   = 1'b1;
          m_seen = '0;
        end
      end
      m_prev = cur;
    end
  endtask

  task automatic step(input logic [6:0] s, input logic [3:0] d, input logic r);
    @(negedge clk);
    seg = s;
    dig = d;
    rst = r;
    @(posedge clk);
    cyc++;
    model_edge();
    #1;
    check("value",      32'(ov_value),     32'(m_value));
    check("valid",      32'(ov_valid),     32'(m_valid));
    check("blank",      32'(ov_blank),     32'(m_blank));
    check("frame_done", 32'(o_frame_done), 32'(m_fd));
    check("error",      32'(o_error),      32'(m_err));
    if (o_frame_done) fd_cnt++;
    if (o_error) er_cnt++;
  endtask

  task automatic hold(input logic [6:0] s, input logic [3:0] d, input int n);
    for (int i = 0; i < n; i++) step(s, d, 1'b0);
  endtask

  initial begin
    logic [6:0] rs;
    logic [3:0] rd;
    int         sel;
    int         len;

    seg = 7'h7F;
    dig = 4'hF;
    rst = 1'b1;

    // Reset held three cycles with arbitrary bus activity.
    for (int i = 0; i < 3; i++) step(7'($urandom), 4'($urandom), 1'b1);
    check("rst_value", 32'(ov_value), 32'h0);
    check("rst_pulses", 32'(fd_cnt + er_cnt), 32'h0);

    // Single digit: capture on the 5th edge, not before.
    hold(7'h12, 4'b1110, 4);
    check("t2_not_yet", 32'(ov_valid), 32'h0);
    step(7'h12, 4'b1110, 1'b0);
    check("t2_nibble", 32'(ov_value[3:0]), 32'h2);
    check("t2_valid", 32'(ov_valid), 32'h1);
    // Held only four edges then changed: no capture.
    hold(7'h7F, 4'hF, 1);
    hold(7'h24, 4'b1110, 4);
    hold(7'h7F, 4'hF, 1);
    check("t2_abort", 32'(ov_value[3:0]), 32'h2);

    // Full scan of four digits, 8 cycles each.
    fd_cnt = 0;
    hold(7'h08, 4'b1110, 8);
    hold(7'h60, 4'b1101, 8);
    hold(7'h31, 4'b1011, 8);
    hold(7'h42, 4'b0111, 4);
    check("t3_fd_early", 32'(fd_cnt), 32'h0);
    step(7'h42, 4'b0111, 1'b0);
    check("t3_fd_edge", 32'(o_frame_done), 32'h1);
    hold(7'h42, 4'b0111, 3);
    check("t3_value", 32'(ov_value), 32'hDCBA);
    check("t3_valid", 32'(ov_valid), 32'hF);
    check("t3_fd_once", 32'(fd_cnt), 32'h1);

    // Invalid pattern on digit 1.
    er_cnt = 0;
    hold(7'h7E, 4'b1101, 8);
    check("t4_err_once", 32'(er_cnt), 32'h1);
    check("t4_valid1", 32'(ov_valid[1]), 32'h0);
    check("t4_nib1", 32'(ov_value[7:4]), 32'hB);

    // Blank on digit 2, then a held multi-hot select.
    hold(7'h7F, 4'b1011, 8);
    check("t5_blank2", 32'(ov_blank[2]), 32'h1);
    check("t5_valid2", 32'(ov_valid[2]), 32'h0);
    er_cnt = 0;
    hold(7'h12, 4'b1100, 10);
    check("t5_multi_err", 32'(er_cnt), 32'h1);
    check("t5_multi_value", 32'(ov_value), 32'hDCBA);
    // Digits 1 and 2 already seen; digits 0 and 3 complete the frame.
    fd_cnt = 0;
    hold(7'h06, 4'b1110, 8);
    hold(7'h30, 4'b0111, 8);
    check("t5_frame", 32'(fd_cnt), 32'h1);

    // Reset on the third stable cycle discards the partial settle.
    hold(7'h4F, 4'b1110, 2);
    step(7'h4F, 4'b1110, 1'b1);
    hold(7'h4F, 4'b1110, 4);
    check("t6_no_cap", 32'(ov_valid), 32'h0);
    step(7'h4F, 4'b1110, 1'b0);
    check("t6_valid0", 32'(ov_valid[0]), 32'h1);
    check("t6_nib0", 32'(ov_value[3:0]), 32'h1);

    // Randomized bus activity against the model.
    for (int n = 0; n < 250; n++) begin
      sel = $urandom_range(0, 9);
      if (sel < 8)       rd = 4'(~(4'b0001 << $urandom_range(0, 3)));
      else if (sel == 8) rd = 4'hF;
      else               rd = 4'($urandom);
      sel = $urandom_range(0, 9);
      if (sel < 6)       rs = hex_tab[$urandom_range(0, 15)];
      else if (sel < 8)  rs = 7'h7F;
      else               rs = 7'($urandom);
      len = $urandom_range(1, 9);
      if ($urandom_range(0, 29) == 0) step(rs, rd, 1'b1);
      hold(rs, rd, len);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/seg7_scan_decoder.md
Name: seg7_scan_decoder

Overview:
- Receive-side counterpart of the hex-to-7-segment encoder.
- Watches a multiplexed, active-low 7-segment display bus (segment lines plus digit-select lines) and qualifies each digit's pattern once it has been stable long enough.
- Decodes each qualified pattern back to a hex nibble and assembles a DIGITS-wide value.
- Used for display loopback self-test and for capturing display output in system benches.

Parameters:
DIGITS, 4, number of multiplexed digits (1..8)
SETTLE_CYCLES, 4, consecutive identical samples required before capture (1..255)

Ports:
i_clk  in  1  clock
i_reset  in  1  synchronous active-high reset
iv_seg_n  in  7  segment lines, active-low, [6]=a [5]=b [4]=c [3]=d [2]=e [1]=f [0]=g
iv_dig_n  in  DIGITS  digit selects, active-low, one-hot when driven
ov_value  out  4*DIGITS  decoded nibbles, digit k at [4k+3:4k]
ov_valid  out  DIGITS  digit k last captured as a valid hex pattern
ov_blank  out  DIGITS  digit k last captured as blank (7'h7F)
o_frame_done  out  1  one-cycle pulse when every digit has been captured since the last pulse
o_error  out  1  one-cycle pulse on an invalid pattern or a multi-hot select

Behaviour:
- Clocking and reset: one clock, i_clk. Reset is synchronous, active-high on i_reset.
- Reset values: all outputs 0; state IDLE; counter 0; seen mask 0; sample register = {7'h7F, all-ones}.
- Input stage: {iv_seg_n, iv_dig_n} is registered into the sample register every cycle.
- Stability counter:
  - Cleared to 0 when the incoming inputs differ from the sample register.
  - Otherwise increments, saturating at SETTLE_CYCLES-1.
- Select classification of the sample register:
  - NONE: all ones.
  - ONE(k): exactly one zero, at bit k.
  - MULTI: anything else.
- States and transitions:
  - IDLE: sample is NONE or MULTI. Entering MULTI from a different sample pulses o_error once. A held MULTI does not repeat the pulse.
  - SETTLING: sample is ONE(k). When the counter equals SETTLE_CYCLES-1, capture and go to HELD.
  - HELD: no re-capture while the sample is unchanged.
  - From any state, a sample change restarts classification with the counter at 0. A change to ONE(k) goes to SETTLING; a change to NONE or MULTI goes to IDLE.
- Latency: inputs held stable from sampling edge E are captured at edge E+SETTLE_CYCLES, and outputs show the capture after that edge. With the default of 4, that is the 5th edge counting E as the 1st. Any change before that edge aborts the capture.
- Capture of digit k, pattern P:
  - P in the canonical table: value[k] <= nibble, valid[k] <= 1, blank[k] <= 0.
  - P = 7'h7F: blank[k] <= 1, valid[k] <= 0, value[k] unchanged.
  - Any other P: o_error pulse, valid[k] <= 0, blank[k] <= 0, value[k] unchanged.
  - In all three cases seen[k] <= 1.
- Canonical table (active-low), strict matching only, no alternate 6/7/9 forms:
  - 0=01 1=4F 2=12 3=06 4=4C 5=24 6=20 7=0F
  - 8=00 9=0C A=08 b=60 C=31 d=42 E=30 F=38
- Frame completion:
  - When a capture makes seen all-ones, o_frame_done pulses on that same edge and seen clears to 0.
  - Re-capturing an already-seen digit does not alter seen.
- Simultaneous events: an invalid-pattern capture that completes a frame pulses both o_error and o_frame_done in the same cycle.
- Reset mid-operation: any partial settle is discarded. The first capture after release needs a full SETTLE_CYCLES of fresh samples.

Decomposition:
- Package seg7_pkg holds:
  - the segment bit-index constants;
  - the 16-entry canonical active-low pattern table;
  - SEG_BLANK = 7'h7F;
  - the state encoding IDLE/SETTLING/HELD.
- Sub-module seg7_pattern_decode: combinational, 7-bit pattern in; nibble, is_hex and is_blank out. It is the exact inverse of the encoder table and is reusable in benches.

Test Plan:
1. Reset: hold i_reset 3 cycles with arbitrary inputs -> all outputs 0; no pulses during or after reset.
2. Single digit, SETTLE_CYCLES=4: iv_dig_n=4'b1110, iv_seg_n=7'h12 held 5 cycles -> after the 5th edge ov_value[3:0]=2 and ov_valid=4'b0001. The same stimulus held only 4 cycles then changed -> no capture.
3. Full scan, 8 cycles per digit, digits 0..3 with patterns 08, 60, 31, 42 -> ov_value=16'hDCBA, ov_valid=4'hF, exactly one o_frame_done pulse, on the digit-3 capture edge.
4. Invalid pattern 7'h7E on digit 1, held 8 cycles -> exactly one o_error pulse, ov_valid[1]=0, ov_value[7:4] unchanged.
5. Blank plus multi-hot:
   - 7'h7F on digit 2 -> ov_blank[2]=1, ov_valid[2]=0, and the digit counts toward the frame.
   - iv_dig_n=4'b1100 held 10 cycles -> one o_error pulse and no capture.
6. Reset mid-settle: assert i_reset on the 3rd stable cycle of digit 0 = 7'h4F -> no capture. After release the same inputs need a full 5 edges, after which ov_value[3:0]=1.
